// File: rtl/trap_ctrl.sv
// Machine-mode trap entry / MRET return sequencer.
// Arbitrates exceptions and interrupts, builds CSR update words, redirects fetch.
module trap_ctrl #(
    parameter int XLEN      = 32,
    parameter int VECTOR_EN = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            exc_valid_i,
    input  logic [3:0]      exc_cause_i,
    input  logic [XLEN-1:0] exc_pc_i,
    input  logic [XLEN-1:0] exc_tval_i,
    input  logic            mret_i,
    input  logic            commit_valid_i,
    input  logic [XLEN-1:0] commit_pc_i,
    input  logic            irq_ext_i,
    input  logic            irq_tim_i,
    input  logic            irq_sw_i,
    input  logic [XLEN-1:0] mstatus_i,
    input  logic [XLEN-1:0] mie_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic            redirect_ready_i,
    output logic            we_exc_o,
    output logic            is_int_o,
    output logic [XLEN-1:0] mcause_o,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] mtval_o,
    output logic [XLEN-1:0] mstatus_o,
    output logic [XLEN-1:0] mip_o,
    output logic            flush_o,
    output logic            busy_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTER = 2'd1,
        RET   = 2'd2,
        REDIR = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mtval;
    logic [XLEN-1:0] r_mstatus;
    logic [XLEN-1:0] r_mip;
    logic [XLEN-1:0] r_redir_pc;
    logic            r_is_int;

    logic            w_ext_ok;
    logic            w_tim_ok;
    logic            w_sw_ok;
    logic            w_int_any;
    logic [3:0]      w_int_code;
    logic            w_take_exc;
    logic            w_take_ret;
    logic            w_take_int;
    logic            w_accept;
    logic            w_vectored;
    logic [XLEN-1:0] w_tvec_base;
    logic [XLEN-1:0] w_int_off;
    logic [XLEN-1:0] w_mstatus_trap;
    logic [XLEN-1:0] w_mstatus_ret;

    // Interrupt eligibility and fixed priority ext > sw > tim.
    always_comb begin
        w_ext_ok   = commit_valid_i & mstatus_i[3] & irq_ext_i & mie_i[11];
        w_sw_ok    = commit_valid_i & mstatus_i[3] & irq_sw_i  & mie_i[3];
        w_tim_ok   = commit_valid_i & mstatus_i[3] & irq_tim_i & mie_i[7];
        w_int_any  = w_ext_ok | w_sw_ok | w_tim_ok;
        w_int_code = 4'd0;
        if (w_ext_ok) begin
            w_int_code = 4'd11;
        end else if (w_sw_ok) begin
            w_int_code = 4'd3;
        end else if (w_tim_ok) begin
            w_int_code = 4'd7;
        end
        w_take_exc = exc_valid_i;
        w_take_ret = !exc_valid_i && mret_i;
        w_take_int = !exc_valid_i && !mret_i && w_int_any;
        w_accept   = w_take_exc | w_take_ret | w_take_int;
    end

    // Trap vector target and mstatus update words.
    always_comb begin
        w_vectored  = (VECTOR_EN != 0) && (mtvec_i[1:0] == 2'b01);
        w_tvec_base = {mtvec_i[XLEN-1:2], 2'b00};
        w_int_off   = {{(XLEN-6){1'b0}}, w_int_code, 2'b00};
        w_mstatus_trap        = mstatus_i;
        w_mstatus_trap[7]     = mstatus_i[3];
        w_mstatus_trap[3]     = 1'b0;
        w_mstatus_trap[12:11] = 2'b11;
        w_mstatus_ret         = mstatus_i;
        w_mstatus_ret[3]      = mstatus_i[7];
        w_mstatus_ret[7]      = 1'b1;
        w_mstatus_ret[12:11]  = 2'b11;
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and state-decoded strobes.
    always_comb begin
        w_state_nxt      = r_state;
        flush_o          = 1'b0;
        we_exc_o         = 1'b0;
        is_int_o         = 1'b0;
        busy_o           = 1'b1;
        redirect_valid_o = 1'b0;
        case (r_state)
            IDLE: begin
                busy_o  = 1'b0;
                flush_o = w_accept;
                if (w_take_ret) begin
                    w_state_nxt = RET;
                end else if (w_accept) begin
                    w_state_nxt = ENTER;
                end
            end
            ENTER: begin
                we_exc_o    = 1'b1;
                is_int_o    = r_is_int;
                w_state_nxt = REDIR;
            end
            RET: begin
                we_exc_o    = 1'b1;
                w_state_nxt = REDIR;
            end
            REDIR: begin
                redirect_valid_o = 1'b1;
                if (redirect_ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Latch CSR update words and redirect target at the accepting cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mcause   <= '0;
            r_mepc     <= '0;
            r_mtval    <= '0;
            r_mstatus  <= '0;
            r_redir_pc <= '0;
            r_is_int   <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_take_exc) begin
                r_mcause   <= {{(XLEN-4){1'b0}}, exc_cause_i};
                r_mepc     <= exc_pc_i;
                r_mtval    <= exc_tval_i;
                r_mstatus  <= w_mstatus_trap;
                r_redir_pc <= w_tvec_base;
                r_is_int   <= 1'b0;
            end else if (w_take_ret) begin
                r_mepc     <= mepc_i;
                r_mstatus  <= w_mstatus_ret;
                r_redir_pc <= {mepc_i[XLEN-1:2], 2'b00};
                r_is_int   <= 1'b0;
            end else if (w_take_int) begin
                r_mcause   <= {1'b1, {(XLEN-5){1'b0}}, w_int_code};
                r_mepc     <= commit_pc_i;
                r_mtval    <= '0;
                r_mstatus  <= w_mstatus_trap;
                r_redir_pc <= w_vectored ? (w_tvec_base + w_int_off)
                                         : w_tvec_base;
                r_is_int   <= 1'b1;
            end
        end
    end

    // Pending-interrupt snapshot, sampled every cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mip <= '0;
        end else begin
            r_mip     <= '0;
            r_mip[11] <= irq_ext_i;
            r_mip[7]  <= irq_tim_i;
            r_mip[3]  <= irq_sw_i;
        end
    end

    assign mcause_o      = r_mcause;
    assign mepc_o        = r_mepc;
    assign mtval_o       = r_mtval;
    assign mstatus_o     = r_mstatus;
    assign mip_o         = r_mip;
    assign redirect_pc_o = r_redir_pc;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed testbench for trap_ctrl.
// Linear stimulus with immediate-assertion checks.
module tb_trap_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        exc_valid_i;
    logic [3:0]  exc_cause_i;
    logic [31:0] exc_pc_i;
    logic [31:0] exc_tval_i;
    logic        mret_i;
    logic        commit_valid_i;
    logic [31:0] commit_pc_i;
    logic        irq_ext_i;
    logic        irq_tim_i;
    logic        irq_sw_i;
    logic [31:0] mstatus_i;
    logic [31:0] mie_i;
    logic [31:0] mtvec_i;
    logic [31:0] mepc_i;
    logic        redirect_ready_i;
    logic        we_exc_o;
    logic        is_int_o;
    logic [31:0] mcause_o;
    logic [31:0] mepc_o;
    logic [31:0] mtval_o;
    logic [31:0] mstatus_o;
    logic [31:0] mip_o;
    logic        flush_o;
    logic        busy_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;

    int n_vec = 0;
    int n_err = 0;

    trap_ctrl #(.XLEN(32), .VECTOR_EN(1)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .exc_valid_i      (exc_valid_i),
        .exc_cause_i      (exc_cause_i),
        .exc_pc_i         (exc_pc_i),
        .exc_tval_i       (exc_tval_i),
        .mret_i           (mret_i),
        .commit_valid_i   (commit_valid_i),
        .commit_pc_i      (commit_pc_i),
        .irq_ext_i        (irq_ext_i),
        .irq_tim_i        (irq_tim_i),
        .irq_sw_i         (irq_sw_i),
        .mstatus_i        (mstatus_i),
        .mie_i            (mie_i),
        .mtvec_i          (mtvec_i),
        .mepc_i           (mepc_i),
        .redirect_ready_i (redirect_ready_i),
        .we_exc_o         (we_exc_o),
        .is_int_o         (is_int_o),
        .mcause_o         (mcause_o),
        .mepc_o           (mepc_o),
        .mtval_o          (mtval_o),
        .mstatus_o        (mstatus_o),
        .mip_o            (mip_o),
        .flush_o          (flush_o),
        .busy_o           (busy_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        exc_valid_i    = 1'b0;
        mret_i         = 1'b0;
        commit_valid_i = 1'b0;
        irq_ext_i      = 1'b0;
        irq_tim_i      = 1'b0;
        irq_sw_i       = 1'b0;
    endtask

    initial begin
        rst_i            = 1'b1;
        exc_cause_i      = 4'd0;
        exc_pc_i         = 32'h0;
        exc_tval_i       = 32'h0;
        commit_pc_i      = 32'h0;
        mstatus_i        = 32'h0;
        mie_i            = 32'h0;
        mtvec_i          = 32'h0;
        mepc_i           = 32'h0;
        redirect_ready_i = 1'b0;
        idle_inputs();
        tick();
        tick();
        chk("rst_we", {31'b0, we_exc_o}, 32'h0);
        chk("rst_busy", {31'b0, busy_o}, 32'h0);
        chk("rst_rv", {31'b0, redirect_valid_o}, 32'h0);
        chk("rst_mcause", mcause_o, 32'h0);
        chk("rst_mip", mip_o, 32'h0);
        chk("rst_rpc", redirect_pc_o, 32'h0);
        rst_i = 1'b0;
        tick();

        // Illegal instruction, direct mtvec
        mstatus_i   = 32'h8;
        mtvec_i     = 32'h200;
        exc_valid_i = 1'b1;
        exc_cause_i = 4'd2;
        exc_pc_i    = 32'h100;
        exc_tval_i  = 32'h13;
        #1;
        chk("ill_flush", {31'b0, flush_o}, 32'h1);
        chk("ill_busy0", {31'b0, busy_o}, 32'h0);
        tick();
        exc_valid_i = 1'b0;
        chk("ill_we", {31'b0, we_exc_o}, 32'h1);
        chk("ill_isint", {31'b0, is_int_o}, 32'h0);
        chk("ill_mcause", mcause_o, 32'h2);
        chk("ill_mepc", mepc_o, 32'h100);
        chk("ill_mtval", mtval_o, 32'h13);
        chk("ill_mstatus", mstatus_o, 32'h1880);
        chk("ill_busy1", {31'b0, busy_o}, 32'h1);
        chk("ill_flush1", {31'b0, flush_o}, 32'h0);
        tick();
        chk("ill_rv", {31'b0, redirect_valid_o}, 32'h1);
        chk("ill_rpc", redirect_pc_o, 32'h200);
        chk("ill_we2", {31'b0, we_exc_o}, 32'h0);
        redirect_ready_i = 1'b1;
        tick();
        redirect_ready_i = 1'b0;
        chk("ill_idle", {31'b0, busy_o}, 32'h0);
        chk("ill_rv0", {31'b0, redirect_valid_o}, 32'h0);

        // External interrupt, vectored mtvec
        mstatus_i      = 32'h8;
        mie_i          = 32'h800;
        mtvec_i        = 32'h301;
        irq_ext_i      = 1'b1;
        commit_valid_i = 1'b1;
        commit_pc_i    = 32'h44;
        #1;
        chk("ext_flush", {31'b0, flush_o}, 32'h1);
        tick();
        idle_inputs();
        chk("ext_we", {31'b0, we_exc_o}, 32'h1);
        chk("ext_isint", {31'b0, is_int_o}, 32'h1);
        chk("ext_mcause", mcause_o, 32'h8000000B);
        chk("ext_mepc", mepc_o, 32'h44);
        chk("ext_mtval", mtval_o, 32'h0);
        chk("ext_mstatus", mstatus_o, 32'h1880);
        chk("ext_mip", mip_o, 32'h800);
        tick();
        chk("ext_rv", {31'b0, redirect_valid_o}, 32'h1);
        chk("ext_rpc", redirect_pc_o, 32'h32C);
        chk("ext_mip0", mip_o, 32'h0);
        redirect_ready_i = 1'b1;
        tick();
        redirect_ready_i = 1'b0;
        chk("ext_idle", {31'b0, busy_o}, 32'h0);

        // Global MIE clear masks every line
        mstatus_i      = 32'h0;
        mie_i          = 32'h888;
        irq_ext_i      = 1'b1;
        irq_tim_i      = 1'b1;
        irq_sw_i       = 1'b1;
        commit_valid_i = 1'b1;
        #1;
        chk("mask_flush", {31'b0, flush_o}, 32'h0);
        tick();
        tick();
        chk("mask_busy", {31'b0, busy_o}, 32'h0);
        chk("mask_we", {31'b0, we_exc_o}, 32'h0);
        chk("mask_mip", mip_o, 32'h888);

        // sw beats tim; wrap of vectored target
        mstatus_i = 32'h8;
        irq_ext_i = 1'b0;
        mtvec_i   = 32'h301;
        tick();
        idle_inputs();
        chk("sw_mcause", mcause_o, 32'h80000003);
        tick();
        chk("sw_rpc", redirect_pc_o, 32'h30C);
        redirect_ready_i = 1'b1;
        tick();
        redirect_ready_i = 1'b0;
        mie_i          = 32'h880;
        mtvec_i        = 32'hFFFFFFF1;
        irq_ext_i      = 1'b1;
        irq_tim_i      = 1'b1;
        commit_valid_i = 1'b1;
        tick();
        idle_inputs();
        chk("wrap_mcause", mcause_o, 32'h8000000B);
        tick();
        chk("wrap_rpc", redirect_pc_o, 32'h1C);
        redirect_ready_i = 1'b1;
        tick();
        redirect_ready_i = 1'b0;

        // Timer only; mtvec mode 2 behaves as direct
        mie_i          = 32'h080;
        mtvec_i        = 32'h402;
        irq_tim_i      = 1'b1;
        commit_valid_i = 1'b1;
        commit_pc_i    = 32'h88;
        tick();
        idle_inputs();
        chk("tim_mcause", mcause_o, 32'h80000007);
        chk("tim_mepc", mepc_o, 32'h88);
        tick();
        chk("tim_rpc", redirect_pc_o, 32'h400);
        redirect_ready_i = 1'b1;
        tick();
        redirect_ready_i = 1'b0;

        // Exception and MRET together: exception wins
        mtvec_i     = 32'h200;
        exc_valid_i = 1'b1;
        mret_i      = 1'b1;
        exc_cause_i = 4'd5;
        exc_pc_i    = 32'h2000;
        exc_tval_i  = 32'hDEAD;
        mepc_i      = 32'h500;
        tick();
        idle_inputs();
        chk("both_we", {31'b0, we_exc_o}, 32'h1);
        chk("both_mcause", mcause_o, 32'h5);
        chk("both_mepc", mepc_o, 32'h2000);
        tick();
        chk("both_rpc", redirect_pc_o, 32'h200);
        redirect_ready_i = 1'b1;
        tick();
        redirect_ready_i = 1'b0;

        // MRET with back-pressured redirect
        mstatus_i = 32'h80;
        mepc_i    = 32'h104;
        mret_i    = 1'b1;
        #1;
        chk("ret_flush", {31'b0, flush_o}, 32'h1);
        tick();
        idle_inputs();
        chk("ret_we", {31'b0, we_exc_o}, 32'h1);
        chk("ret_isint", {31'b0, is_int_o}, 32'h0);
        chk("ret_mstatus", mstatus_o, 32'h1888);
        chk("ret_mepc", mepc_o, 32'h104);
        chk("ret_mcause", mcause_o, 32'h5);
        chk("ret_mtval", mtval_o, 32'hDEAD);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ret_hold_rv", {31'b0, redirect_valid_o}, 32'h1);
            chk("ret_hold_pc", redirect_pc_o, 32'h104);
        end
        redirect_ready_i = 1'b1;
        tick();
        redirect_ready_i = 1'b0;
        chk("ret_idle", {31'b0, busy_o}, 32'h0);

        // Reset in REDIR drops everything at once
        exc_valid_i = 1'b1;
        exc_cause_i = 4'd1;
        tick();
        idle_inputs();
        tick();
        chk("rr_rv1", {31'b0, redirect_valid_o}, 32'h1);
        rst_i = 1'b1;
        #1;
        chk("rr_rv0", {31'b0, redirect_valid_o}, 32'h0);
        chk("rr_busy", {31'b0, busy_o}, 32'h0);
        chk("rr_rpc", redirect_pc_o, 32'h0);
        rst_i = 1'b0;
        tick();
        tick();
        chk("rr_idle", {31'b0, busy_o}, 32'h0);
        chk("rr_we", {31'b0, we_exc_o}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
